// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption core: ROUNDS_PER_CYCLE chained rounds per clock,
// on-the-fly key expansion, start/busy/done handshake.
module aes128_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] inp_data,
  input  logic [127:0] inp_key,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_data,
  output logic [127:0] out_key
);

  localparam int ITER = (ROUNDS_PER_CYCLE > 0) ? 10 / ROUNDS_PER_CYCLE : 0;

  if ((ROUNDS_PER_CYCLE < 1) || (ITER * ROUNDS_PER_CYCLE != 10)) begin : g_bad_rpc
    $error("aes128_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [127:0] state_reg, key_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   rnd;
  logic [127:0] st_nxt, key_nxt;
  logic [7:0]   rcon_nxt;
  logic         last_blk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by square-and-multiply; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte i of the block sits at row i%4, column i/4.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[r + 4*c] = b[r + 4*((c + r) % 4)];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      if (last)
        res[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return res ^ k;
  endfunction

  // rcon_reg always holds the constant for round rnd.
  always_comb begin
    st_nxt   = state_reg;
    key_nxt  = key_reg;
    rcon_nxt = rcon_reg;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      key_nxt  = next_key(key_nxt, rcon_nxt);
      st_nxt   = aes_round(st_nxt, key_nxt, (rnd + 4'(i)) == 4'd10);
      rcon_nxt = xtime(rcon_nxt);
    end
  end

  assign last_blk = (rnd + 4'(ROUNDS_PER_CYCLE - 1)) == 4'd10;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_key   <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= 4'd0;
      rcon_reg  <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg <= inp_data ^ inp_key;
            key_reg   <= inp_key;
            rnd       <= 4'd1;
            rcon_reg  <= 8'h01;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          state_reg <= st_nxt;
          key_reg   <= key_nxt;
          rcon_reg  <= rcon_nxt;
          rnd       <= rnd + 4'(ROUNDS_PER_CYCLE);
          if (last_blk) begin
            out_data <= st_nxt;
            out_key  <= key_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_engine.sv
// Scoreboard bench for aes128_round_engine: four instances (R = 1, 2, 5, 10) share
// data/key inputs; each has its own start and expected-result queue.
module tb_aes128_round_engine;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] k10;
    logic         chk_key;
    int           acc_edge;
  } exp_t;

  logic         clk, rst;
  logic [3:0]   start_v;
  logic [127:0] pt, key;
  logic         busy_v [4];
  logic         done_v [4];
  logic [127:0] od [4];
  logic [127:0] ok [4];

  logic [127:0] cur_ct, cur_k10;
  logic         cur_chk, chk_en;
  exp_t         sb [4][$];
  logic [127:0] last_exp [4];
  int           acc_cnt [4];
  int           done_cnt [4];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  function automatic int rpc_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_round_engine #(.ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .inp_data (pt),
      .inp_key  (key),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .out_data (od[g]),
      .out_key  (ok[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor: completions pop the scoreboard first, then new accepts push onto it.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (rst) begin
        sb[g].delete();
        last_exp[g] = '0;
      end else if (chk_en) begin
        if (done_v[g]) begin
          done_cnt[g]++;
          if (sb[g].size() == 0) begin
            check($sformatf("spurious_done_r%0d", rpc_of(g)), 128'(done_v[g]), 128'd0);
          end else begin
            e = sb[g].pop_front();
            last_exp[g] = e.ct;
            check($sformatf("out_data_r%0d", rpc_of(g)), od[g], e.ct);
            if (e.chk_key) check($sformatf("out_key_r%0d", rpc_of(g)), ok[g], e.k10);
            check($sformatf("latency_r%0d", rpc_of(g)), 128'(cyc - e.acc_edge + 1),
                  128'(10 / rpc_of(g) + 1));
          end
        end else begin
          check($sformatf("hold_r%0d", rpc_of(g)), od[g], last_exp[g]);
        end
        if (start_v[g] && !busy_v[g]) begin
          e.ct = cur_ct;
          e.k10 = cur_k10;
          e.chk_key = cur_chk;
          e.acc_edge = cyc + 1;
          sb[g].push_back(e);
          acc_cnt[g]++;
        end
      end
    end
  end

  task automatic set_inputs(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c,
                            input logic [127:0] k10, input logic chk);
    pt = p; key = k; cur_ct = c; cur_k10 = k10; cur_chk = chk;
  endtask

  task automatic run_block(input logic [3:0] mask, input logic [127:0] p, input logic [127:0] k,
                           input logic [127:0] c, input logic [127:0] k10, input logic chk);
    @(posedge clk); #1;
    set_inputs(p, k, c, k10, chk);
    start_v = mask;
    @(posedge clk); #1;
    start_v = '0;
  endtask

  task automatic wait_idle(input int budget);
    int pending;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      pending = 0;
      for (int g = 0; g < 4; g++) pending += sb[g].size() + int'(busy_v[g]);
      if (pending == 0) return;
    end
    check("idle_timeout", 128'(pending), 128'd0);
  endtask

  task automatic wait_acc(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (acc_cnt[0] >= target) return;
    end
    check("accept_timeout", 128'(acc_cnt[0]), 128'(target));
  endtask

  initial begin
    int a0, d0;
    rst = 1'b1; start_v = '0; chk_en = 1'b0;
    set_inputs('0, '0, '0, '0, 1'b0);
    for (int g = 0; g < 4; g++) begin acc_cnt[g] = 0; done_cnt[g] = 0; last_exp[g] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_busy", 128'(busy_v[g]), 128'd0);
      check("rst_done", 128'(done_v[g]), 128'd0);
      check("rst_out_key", ok[g], 128'd0);
    end

    run_block(4'hf, PT_A, KEY_A, CT_A, K10_A, 1'b1);
    wait_idle(40);
    run_block(4'hf, PT_B, KEY_B, CT_B, K10_B, 1'b1);
    wait_idle(40);
    run_block(4'hf, '0, '0, CT_Z, '0, 1'b0);
    wait_idle(40);

    // Start held high: second block accepted in the done cycle; inputs change mid-block.
    a0 = acc_cnt[0]; d0 = done_cnt[0];
    @(posedge clk); #1;
    set_inputs(PT_B, KEY_B, CT_B, K10_B, 1'b1);
    start_v = 4'b0001;
    wait_acc(a0 + 1, 10);
    set_inputs(PT_A, KEY_A, CT_A, K10_A, 1'b1);
    wait_acc(a0 + 2, 30);
    start_v = '0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    wait_idle(40);
    check("b2b_done_count", 128'(done_cnt[0] - d0), 128'd2);

    // Extra start pulses with garbage inputs while busy must be ignored.
    d0 = done_cnt[0];
    run_block(4'b0001, PT_A, KEY_A, CT_A, K10_A, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      start_v = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      pt = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
    end
    start_v = '0;
    wait_idle(40);
    check("busy_start_done_count", 128'(done_cnt[0] - d0), 128'd1);

    // Reset in the middle of an R=1 block discards it.
    run_block(4'b0001, PT_A, KEY_A, CT_A, K10_A, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy_v[0]), 128'd0);
    check("midrst_done", 128'(done_v[0]), 128'd0);
    check("midrst_out_data", od[0], 128'd0);
    check("midrst_out_key", ok[0], 128'd0);
    d0 = done_cnt[0];
    repeat (15) @(posedge clk);
    check("midrst_no_done", 128'(done_cnt[0] - d0), 128'd0);
    run_block(4'b0001, PT_A, KEY_A, CT_A, K10_A, 1'b1);
    wait_idle(40);
    check("post_rst_done_count", 128'(done_cnt[0] - d0), 128'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
